// File: rtl/alu_frame_serializer.sv
// alu_frame_serializer: packs operands and opcode into ALU serial frames (data frames + CRC command frame) on sout.
module alu_frame_serializer #(
  parameter int DATA_BYTES   = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [8*DATA_BYTES-1:0] req_a,
  input  logic [8*DATA_BYTES-1:0] req_b,
  input  logic [2:0]              req_op,
  input  logic [1:0]              req_err,
  output logic                    sout,
  output logic                    busy,
  output logic                    done
);
  localparam int NB = 16 * DATA_BYTES;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FW = $clog2(2 * DATA_BYTES) > 0 ? $clog2(2 * DATA_BYTES) : 1;
  localparam int BW = GAP_BITS > 16 ? $clog2(GAP_BITS) : 4;
  localparam logic [CW-1:0] CLAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FW-1:0] FLAST = FW'(2 * DATA_BYTES - 1);
  localparam logic [BW-1:0] GLAST = BW'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
  localparam logic [BW-1:0] STOP  = BW'(10);

  typedef enum logic [1:0] {IDLE, DATA, CMD, GAP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [FW-1:0]  frm_q, frm_d;
  logic [NB-1:0]  sh_q, sh_d;
  logic [3:0]     crc_q, crc_d;
  logic [2:0]     op_q, op_d;
  logic [1:0]     err_q, err_d;
  logic           last_cyc, payload, type_bit, pay_bit;
  logic [3:0]     crc_cmd, crc_tx;
  logic [7:0]     cmd_byte;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    return {c[2:0], 1'b0} ^ ((c[3] ^ d) ? 4'h3 : 4'h0);
  endfunction

  assign last_cyc = cyc_q == CLAST;
  assign payload  = bit_q >= BW'(2) && bit_q <= BW'(9);
  // The trailing {1,op} CRC steps are folded in combinationally once all data bits are absorbed.
  assign crc_cmd  = crc_step(crc_step(crc_step(crc_step(crc_q, 1'b1), op_q[2]), op_q[1]), op_q[0]);
  assign crc_tx   = err_q == 2'b01 ? crc_cmd + 4'd1 : crc_cmd;
  assign cmd_byte = {1'b0, op_q, crc_tx};
  assign type_bit = state_q == CMD || (err_q == 2'b10 && frm_q == FLAST);
  assign pay_bit  = state_q == DATA ? sh_q[NB-1] : cmd_byte[3'(4'd9 - bit_q[3:0])];
  assign sout     = (state_q == IDLE || state_q == GAP) ? 1'b1 :
                    bit_q == '0 ? 1'b0 : bit_q == BW'(1) ? type_bit : bit_q == STOP ? 1'b1 : pay_bit;
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = last_cyc && ((state_q == GAP && bit_q == GLAST) ||
                                  (GAP_BITS == 0 && state_q == CMD && bit_q == STOP));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    frm_d   = frm_q;
    sh_d    = sh_q;
    crc_d   = crc_q;
    op_d    = op_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (req_valid) begin
        state_d = DATA;
        sh_d    = {req_b, req_a};
        op_d    = req_op;
        err_d   = req_err;
        crc_d   = '0;
        cyc_d   = '0;
        bit_d   = '0;
        frm_d   = '0;
      end
    end else begin
      cyc_d = last_cyc ? '0 : cyc_q + 1'b1;
      if (state_q == DATA && payload && cyc_q == '0) crc_d = crc_step(crc_q, sh_q[NB-1]);
      if (last_cyc) begin
        if (state_q == DATA && payload) sh_d = {sh_q[NB-2:0], 1'b0};
        if (state_q == GAP) begin
          bit_d   = bit_q == GLAST ? '0 : bit_q + 1'b1;
          state_d = bit_q == GLAST ? IDLE : GAP;
        end else if (bit_q == STOP) begin
          bit_d = '0;
          if (state_q == CMD) state_d = GAP_BITS == 0 ? IDLE : GAP;
          else begin
            frm_d   = frm_q == FLAST ? '0 : frm_q + 1'b1;
            state_d = frm_q == FLAST ? CMD : DATA;
          end
        end else bit_d = bit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      frm_q   <= '0;
      sh_q    <= '0;
      crc_q   <= '0;
      op_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_frame_serializer.sv
// tb_alu_frame_serializer: randomized and directed checks of the serializer against a packet-level reference model.
module tb_alu_frame_serializer;
  logic clk = 0, rst = 1;
  logic v0 = 0, r0, so0, bz0, dn0;
  logic v1 = 0, r1, so1, bz1, dn1;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0] op0 = 0, op1 = 0;
  logic [1:0] e0 = 0, e1 = 0;
  int ncmp = 0, nfail = 0, acc0 = 0;
  logic [98:0] last_pkt;

  always #5 clk = ~clk;

  alu_frame_serializer u0 (.clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0), .req_a(a0), .req_b(b0),
    .req_op(op0), .req_err(e0), .sout(so0), .busy(bz0), .done(dn0));
  alu_frame_serializer #(.DATA_BYTES(4), .CLKS_PER_BIT(3), .GAP_BITS(0)) u1 (.clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(r1), .req_a(a1), .req_b(b1), .req_op(op1), .req_err(e1), .sout(so1),
    .busy(bz1), .done(dn1));

  always @(posedge clk) if (!rst && v0 && r0) acc0++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of msg(x)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] crc_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0};
    for (int i = 71; i >= 4; i--) if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic logic [98:0] exp_pkt(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                          input logic [1:0] err);
    logic [98:0] p;
    logic [7:0] byt;
    logic [3:0] c;
    p = '0;
    for (int f = 0; f < 8; f++) begin
      byt = f < 4 ? b[31-8*f -: 8] : a[63-8*f -: 8];
      p = {p[87:0], 1'b0, (err == 2'b10 && f == 7), byt, 1'b1};
    end
    c = crc_model(a, b, op);
    if (err == 2'b01) c = c + 4'd1;
    return {p[87:0], 1'b0, 1'b1, 1'b0, op, c, 1'b1};
  endfunction

  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [1:0] err, input bit keep, input bit b2b);
    int w, c, total, done_at, done_cnt;
    bit busy_ok, stable_ok;
    logic s, cur;
    logic [98:0] pkt;
    if (d == 1) begin a1 = a; b1 = b; op1 = op; e1 = err; v1 = 1; end
    else begin a0 = a; b0 = b; op0 = op; e0 = err; v0 = 1; end
    w = 0;
    while (!(d == 1 ? r1 : r0) && w < 1000) begin @(negedge clk); w++; end
    if (w >= 1000) chk("ready_wait", d == 1 ? r1 : r0, 1);
    if (b2b) chk("b2b_wait", w, 0);
    @(posedge clk);
    #1;
    if (d == 1) v1 = keep; else v0 = keep;
    c = d == 1 ? 3 : 1;
    total = (99 + (d == 1 ? 0 : 2)) * c;
    pkt = '0; done_at = 0; done_cnt = 0; busy_ok = 1; stable_ok = 1; cur = 1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      s = d == 1 ? so1 : so0;
      if (d == 1 ? dn1 : dn0) begin done_cnt++; if (done_at == 0) done_at = k; end
      if (!(d == 1 ? bz1 : bz0)) busy_ok = 0;
      if ((k - 1) / c >= 99) begin
        if (s !== 1'b1) stable_ok = 0;
      end else if ((k - 1) % c == 0) begin
        cur = s;
        pkt = {pkt[97:0], s};
      end else if (s !== cur) stable_ok = 0;
    end
    chk("packet", pkt, exp_pkt(a, b, op, err));
    chk("done_cycle", done_at, total);
    chk("done_count", done_cnt, 1);
    chk("busy_span", busy_ok, 1);
    chk("bit_stable", stable_ok, 1);
    @(negedge clk);
    chk("ready_after", d == 1 ? r1 : r0, 1);
    chk("busy_after", d == 1 ? bz1 : bz0, 0);
    last_pkt = pkt;
  endtask

  initial begin
    int acc_before;
    logic [31:0] ra, rb;
    #1;
    chk("rst_sout", so0, 1);
    chk("rst_busy", bz0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_ready", r0, 1);
    chk("rst_sout1", so1, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    xfer(0, 32'h0, 32'h0, 3'b000, 2'b00, 0, 0);
    chk("zero_crc", last_pkt[4:1], 4'hB);
    xfer(0, 32'h0, 32'h0, 3'b100, 2'b01, 0, 0);
    chk("crc_plus1", last_pkt[4:1], 4'(crc_model(32'h0, 32'h0, 3'b100) + 4'd1));
    xfer(0, 32'h0000_00FF, 32'h0, 3'b000, 2'b10, 0, 0);
    chk("bad_type_frame", last_pkt[21:11], 11'b0_1_11111111_1);
    chk("bad_type_crc", last_pkt[4:1], crc_model(32'h0000_00FF, 32'h0, 3'b000));
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      xfer(0, ra, rb, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      xfer(1, ra, rb, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 0, 0);
    end
    a0 = $urandom; b0 = $urandom; op0 = 3'b101; e0 = 0; v0 = 1;
    while (!r0) @(negedge clk);
    @(posedge clk);
    #1 v0 = 0;
    repeat (40) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_sout", so0, 1);
    chk("midrst_ready", r0, 1);
    chk("midrst_done", dn0, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    ra = $urandom; rb = $urandom;
    xfer(0, ra, rb, 3'b011, 2'b00, 0, 0);
    acc_before = acc0;
    ra = $urandom; rb = $urandom;
    xfer(0, ra, rb, 3'b001, 2'b00, 1, 0);
    ra = $urandom; rb = $urandom;
    xfer(0, ra, rb, 3'b010, 2'b01, 1, 1);
    ra = $urandom; rb = $urandom;
    xfer(0, ra, rb, 3'b110, 2'b10, 0, 1);
    repeat (20) @(negedge clk);
    chk("b2b_accepts", acc0 - acc_before, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
